alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one integer ALU instance between two requesters: port 0 (integer pipeline) and port 1 (FP unit exponent/mantissa helper ops).
- Arbitrates per cycle with round-robin or fixed priority.
- Drives the shared ALU combinationally and registers each result into a per-port response buffer with a valid/ready handshake.
- Sits between the execute stage, the FPU sequencer and the ALU.

Parameters:
- N, 32, operand/result width; passed to the ALU.
- RR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority with port 0 highest.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- p0_valid  input  1  port 0 request valid.
- p0_ready  output  1  port 0 request accepted this cycle (equals the grant).
- p0_a  input  N  port 0 operand A.
- p0_b  input  N  port 0 operand B.
- p0_ctrl  input  2  port 0 op: 00 add, 01 sub, 10 and, 11 or.
- p0_rsp_valid  output  1  port 0 response buffer full.
- p0_rsp_ready  input  1  port 0 consumer takes the response.
- p0_rsp_result  output  N  port 0 registered ALU result.
- p0_rsp_zero  output  1  port 0 registered zero flag.
- p1_valid, p1_ready, p1_a, p1_b, p1_ctrl, p1_rsp_valid, p1_rsp_ready, p1_rsp_result, p1_rsp_zero: same as port 0, for port 1.

Behaviour:
- Reset (async, rst=1): pX_rsp_valid=0, pX_rsp_result=0, pX_rsp_zero=0, last_grant=1 (port 0 wins the first contention). pX_ready is combinational and reads 0 while rst=1.
- Eligibility: elig_i = pi_valid && (!pi_rsp_valid || pi_rsp_ready). A full buffer being drained this cycle counts as free.
- Grant (combinational, at most one-hot):
  - Only one port eligible: grant that port.
  - Both eligible, RR=1: grant the port != last_grant.
  - Both eligible, RR=0: grant port 0.
  - Neither eligible: no grant.
- pi_ready = grant_i. Ready depends on valid by design; requesters must not make valid depend on ready.
- ALU input mux:
  - Granted port's a/b/ctrl drive the ALU.
  - No grant: a=0, b=0, ctrl=00 (no operand toggling).
- Latency: exactly 1 cycle, request handshake to response.
  - On edge with grant_i: pi_rsp_result <= ALU result, pi_rsp_zero <= ALU zero, pi_rsp_valid <= 1.
- Response drain: on edge with pi_rsp_valid && pi_rsp_ready && !grant_i, set pi_rsp_valid <= 0; result and zero hold their last value.
- Simultaneous drain and grant on the same port: buffer is overwritten and valid stays 1. This gives back-to-back throughput of 1 op/cycle per port.
- last_grant updates only on a cycle with a grant; it holds when idle.
- Unheld request: if pi_valid drops without a grant, the request is lost. There is no internal request buffering.
- Arithmetic: N-bit wraparound on add/sub, no carry/overflow output. Zero = (result == 0).
- Reset mid-operation: the in-flight result is discarded and no response is produced after rst deasserts.
- Fairness: with RR=1 and both ports continuously eligible, grants alternate 0,1,0,1…
- Starvation: with RR=0, port 1 starves while port 0 stays eligible. This is accepted.

Decomposition:
- Shared package: the ALU op encodings (ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11) and the port-index constants (PORT_INT=0, PORT_FP=1).
- Sub-module: the existing N-bit `alu`, instantiated once.
- Response buffer: written as one small per-port register block, instantiated twice; it is not worth a separate module.

Test Plan:
1. Reset check: assert rst mid-simulation while p0_rsp_valid=1 → all rsp outputs go to 0 immediately (async), no response after release, first contention after release grants port 0.
2. Single port: p0 add a=32'h7FFF_FFFF, b=1 → next cycle p0_rsp_result=32'h8000_0000, zero=0. Then p0 sub a=5, b=5 → result 0, zero=1.
3. Contention, RR=1: both valid for 4 cycles with rsp_ready=1, p0 and 3, p1 or 3 → grants 0,1,0,1. p0 result 32'h3 (a=7, b=3), p1 result 32'h7 (a=5, b=2), 1 response/cycle per port on alternate cycles.
4. Backpressure: p1_rsp_ready=0 with p1_rsp_valid=1, p1_valid=1 → p1_ready=0 and the buffer holds; port 0 is still granted every cycle. Raise p1_rsp_ready → grant to p1 on that same cycle, new result next edge.
5. Fixed priority, RR=0: both valid for 3 cycles → p0 granted every cycle, p1_ready=0. p0_valid drops → p1 granted that cycle.
6. Wraparound and idle: p1 sub a=0, b=1 → result 32'hFFFF_FFFF. No requests → ALU inputs are 0 and last_grant is unchanged.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_arbiter_pkg
// Shared definitions for the ALU arbiter slice.
//   ALU_ADD/SUB/AND/OR : 2-bit ALU operation encodings (ctrl field)
//   port_e             : requester index (PORT_INT = integer pipe, PORT_FP = FPU)
//   NUM_PORTS          : number of requesters sharing the ALU
// -----------------------------------------------------------------------------
package alu_arbiter_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic {
        PORT_INT = 1'b0,
        PORT_FP  = 1'b1
    } port_e;

    localparam int NUM_PORTS = 2;

endpackage

// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
// One requester port of the ALU arbiter: request handshake plus the
// registered response handshake.
//   valid/ready             : request handshake (ready = grant, may depend on valid)
//   a, b, ctrl              : operands and ALU op
//   rsp_valid/rsp_ready     : response buffer full / consumer takes it
//   rsp_result, rsp_zero    : registered ALU result and zero flag
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
    parameter int N = 32
);

    logic         valid;
    logic         ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [1:0]   ctrl;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_result;
    logic         rsp_zero;

    modport master (
        output valid, a, b, ctrl, rsp_ready,
        input  ready, rsp_valid, rsp_result, rsp_zero
    );

    modport slave (
        input  valid, a, b, ctrl, rsp_ready,
        output ready, rsp_valid, rsp_result, rsp_zero
    );

endinterface

// File: rtl/alu_arbiter_alu.sv
// -----------------------------------------------------------------------------
// alu
// Purely combinational N-bit integer ALU shared by the arbiter.
//   a, b   : operands
//   ctrl   : 00 add, 01 sub, 10 and, 11 or
//   result : N-bit result, add/sub wrap around (no carry/overflow out)
//   zero   : result == 0
// -----------------------------------------------------------------------------
module alu
    import alu_arbiter_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   ctrl,
    output logic [N-1:0] result,
    output logic         zero
);

    always_comb begin
        result = '0;
        case (ctrl)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one integer ALU between the integer pipeline (p0) and the FPU helper
// (p1). One request is granted per cycle, the ALU is driven combinationally
// from the granted port, and the result lands in that port's response buffer
// on the next rising edge (1-cycle latency).
//   clk  : clock
//   rst  : asynchronous active-high reset
//   p0   : integer pipeline port (alu_arbiter_if.slave)
//   p1   : FPU helper port       (alu_arbiter_if.slave)
// Parameters: N = data width, RR = 1 round-robin / 0 fixed priority (p0 first).
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int N  = 32,
    parameter bit RR = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  p0,
    alu_arbiter_if.slave  p1
);

    // Per-port views of the two interfaces so both ports share one generate body.
    logic         req_valid      [NUM_PORTS];
    logic [N-1:0] req_a          [NUM_PORTS];
    logic [N-1:0] req_b          [NUM_PORTS];
    logic [1:0]   req_ctrl       [NUM_PORTS];
    logic         rsp_ready      [NUM_PORTS];
    logic         elig           [NUM_PORTS];

    logic         rsp_valid_reg  [NUM_PORTS];
    logic [N-1:0] rsp_result_reg [NUM_PORTS];
    logic         rsp_zero_reg   [NUM_PORTS];

    logic [1:0]   grant;
    port_e        last_grant_reg;

    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [1:0]   alu_ctrl;
    logic [N-1:0] alu_result;
    logic         alu_zero;

    assign req_valid[0] = p0.valid;
    assign req_a[0]     = p0.a;
    assign req_b[0]     = p0.b;
    assign req_ctrl[0]  = p0.ctrl;
    assign rsp_ready[0] = p0.rsp_ready;

    assign req_valid[1] = p1.valid;
    assign req_a[1]     = p1.a;
    assign req_b[1]     = p1.b;
    assign req_ctrl[1]  = p1.ctrl;
    assign rsp_ready[1] = p1.rsp_ready;

    // Grant is gated by rst so ready reads 0 throughout reset.
    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            if (elig[0] && elig[1]) begin
                if (RR && (last_grant_reg == PORT_INT)) begin
                    grant[1] = 1'b1;
                end else begin
                    grant[0] = 1'b1;
                end
            end else begin
                grant[0] = elig[0];
                grant[1] = elig[1];
            end
        end
    end

    // Idle cycles park the ALU on zero operands to avoid needless toggling.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = ALU_ADD;
        if (grant[0]) begin
            alu_a    = req_a[0];
            alu_b    = req_b[0];
            alu_ctrl = req_ctrl[0];
        end else if (grant[1]) begin
            alu_a    = req_a[1];
            alu_b    = req_b[1];
            alu_ctrl = req_ctrl[1];
        end
    end

    alu #(
        .N (N)
    ) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .ctrl   (alu_ctrl),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Round-robin pointer only moves when something was actually granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg <= PORT_FP;
        end else if (grant[0]) begin
            last_grant_reg <= PORT_INT;
        end else if (grant[1]) begin
            last_grant_reg <= PORT_FP;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            // A buffer that is being drained this cycle counts as free.
            assign elig[gi] = req_valid[gi] && (!rsp_valid_reg[gi] || rsp_ready[gi]);

            // Response buffer: a grant overwrites (even while draining), so a
            // port can sustain one op per cycle; a drain alone only clears valid.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rsp_valid_reg[gi]  <= 1'b0;
                    rsp_result_reg[gi] <= '0;
                    rsp_zero_reg[gi]   <= 1'b0;
                end else if (grant[gi]) begin
                    rsp_valid_reg[gi]  <= 1'b1;
                    rsp_result_reg[gi] <= alu_result;
                    rsp_zero_reg[gi]   <= alu_zero;
                end else if (rsp_valid_reg[gi] && rsp_ready[gi]) begin
                    rsp_valid_reg[gi]  <= 1'b0;
                end
            end
        end
    endgenerate

    assign p0.ready      = grant[0];
    assign p0.rsp_valid  = rsp_valid_reg[0];
    assign p0.rsp_result = rsp_result_reg[0];
    assign p0.rsp_zero   = rsp_zero_reg[0];

    assign p1.ready      = grant[1];
    assign p1.rsp_valid  = rsp_valid_reg[1];
    assign p1.rsp_result = rsp_result_reg[1];
    assign p1.rsp_zero   = rsp_zero_reg[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter. Two instances: dut_rr (round-robin) and
// dut_fp (fixed priority). Expected responses are queued when a grant is
// expected and popped when the response buffer should show them.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [32:0] q0[$];
    logic [32:0] q1[$];
    logic [32:0] fq0[$];
    logic [32:0] fq1[$];
    port_e       lg;    // expected last grant of dut_rr

    alu_arbiter_if #(.N(32)) rr0 ();
    alu_arbiter_if #(.N(32)) rr1 ();
    alu_arbiter_if #(.N(32)) fp0 ();
    alu_arbiter_if #(.N(32)) fp1 ();

    alu_arbiter #(.N(32), .RR(1'b1)) dut_rr (
        .clk (clk),
        .rst (rst),
        .p0  (rr0),
        .p1  (rr1)
    );

    alu_arbiter #(.N(32), .RR(1'b0)) dut_fp (
        .clk (clk),
        .rst (rst),
        .p0  (fp0),
        .p1  (fp1)
    );

    always #5 clk = ~clk;

    task automatic drive_rr(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                            input logic [1:0] c0, input logic r0,
                            input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                            input logic [1:0] c1, input logic r1);
        rr0.valid = v0; rr0.a = a0; rr0.b = b0; rr0.ctrl = c0; rr0.rsp_ready = r0;
        rr1.valid = v1; rr1.a = a1; rr1.b = b1; rr1.ctrl = c1; rr1.rsp_ready = r1;
    endtask

    task automatic drive_fp(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                            input logic [1:0] c0, input logic r0,
                            input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                            input logic [1:0] c1, input logic r1);
        fp0.valid = v0; fp0.a = a0; fp0.b = b0; fp0.ctrl = c0; fp0.rsp_ready = r0;
        fp1.valid = v1; fp1.a = a1; fp1.b = b1; fp1.ctrl = c1; fp1.rsp_ready = r1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_rr(1'b1, 32'd1, 32'd2, ALU_ADD, 1'b0, 1'b1, 32'd3, 32'd4, ALU_ADD, 1'b0);
        drive_fp(1'b1, 32'd1, 32'd2, ALU_ADD, 1'b0, 1'b1, 32'd3, 32'd4, ALU_ADD, 1'b0);
        #2;
        checks++;
        if ({rr0.ready, rr1.ready, fp0.ready, fp1.ready} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready got=%b exp=0000", {rr0.ready, rr1.ready, fp0.ready, fp1.ready});
        end
        @(posedge clk); #1;
        checks++;
        if ({rr0.rsp_valid, rr0.rsp_zero, rr0.rsp_result} !== 34'd0) begin
            errors++;
            $display("FAIL reset_rsp_rr0 got=%h exp=0", {rr0.rsp_valid, rr0.rsp_zero, rr0.rsp_result});
        end
        checks++;
        if ({rr1.rsp_valid, rr1.rsp_zero, rr1.rsp_result} !== 34'd0) begin
            errors++;
            $display("FAIL reset_rsp_rr1 got=%h exp=0", {rr1.rsp_valid, rr1.rsp_zero, rr1.rsp_result});
        end
        checks++;
        if ({fp0.rsp_valid, fp1.rsp_valid, fp0.rsp_result, fp1.rsp_result} !== 66'd0) begin
            errors++;
            $display("FAIL reset_rsp_fp got=%b%b exp=00", fp0.rsp_valid, fp1.rsp_valid);
        end
        rst = 1'b0;
        lg  = PORT_FP;
        drive_rr(1'b0, 32'd0, 32'd0, ALU_ADD, 1'b1, 1'b0, 32'd0, 32'd0, ALU_ADD, 1'b1);
        drive_fp(1'b0, 32'd0, 32'd0, ALU_ADD, 1'b1, 1'b0, 32'd0, 32'd0, ALU_ADD, 1'b1);
        @(posedge clk); #1;
        $display("reset released");
    endtask

    task automatic test_contention_rr();
        logic [1:0]  eg;
        logic [32:0] e;
        drive_rr(1'b1, 32'd7, 32'd3, ALU_AND, 1'b1, 1'b1, 32'd5, 32'd2, ALU_OR, 1'b1);
        for (int i = 0; i < 4; i++) begin
            eg = (lg == PORT_INT) ? 2'b10 : 2'b01;
            #2;
            checks++;
            if ({rr1.ready, rr0.ready} !== eg) begin
                errors++;
                $display("FAIL rr_grant cyc=%0d got=%b exp=%b", i, {rr1.ready, rr0.ready}, eg);
            end
            if (eg[0]) q0.push_back({1'b0, 32'h3});
            else       q1.push_back({1'b0, 32'h7});
            lg = eg[0] ? PORT_INT : PORT_FP;
            @(posedge clk); #1;
            if (eg[0]) begin
                e = q0.pop_front();
                checks++;
                if ({rr0.rsp_valid, rr0.rsp_zero, rr0.rsp_result} !== {1'b1, e}) begin
                    errors++;
                    $display("FAIL rr_rsp0 got=%h exp=%h", {rr0.rsp_valid, rr0.rsp_zero, rr0.rsp_result}, {1'b1, e});
                end
                checks++;
                if (rr1.rsp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rr_idle1 got=%b exp=0", rr1.rsp_valid);
                end
                $display("contention cyc=%0d p0 result=%h", i, rr0.rsp_result);
            end else begin
                e = q1.pop_front();
                checks++;
                if ({rr1.rsp_valid, rr1.rsp_zero, rr1.rsp_result} !== {1'b1, e}) begin
                    errors++;
                    $display("FAIL rr_rsp1 got=%h exp=%h", {rr1.rsp_valid, rr1.rsp_zero, rr1.rsp_result}, {1'b1, e});
                end
                checks++;
                if (rr0.rsp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rr_idle0 got=%b exp=0", rr0.rsp_valid);
                end
                $display("contention cyc=%0d p1 result=%h", i, rr1.rsp_result);
            end
        end
        drive_rr(1'b0, 32'd0, 32'd0, ALU_ADD, 1'b1, 1'b0, 32'd0, 32'd0, ALU_ADD, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic test_single_port();
        logic [32:0] e;
        drive_rr(1'b1, 32'h7FFF_FFFF, 32'd1, ALU_ADD, 1'b1, 1'b0, 32'd0, 32'd0, ALU_ADD, 1'b1);
        #2;
        checks++;
        if ({rr1.ready, rr0.ready} !== 2'b01) begin
            errors++;
            $display("FAIL single_grant_add got=%b exp=01", {rr1.ready, rr0.ready});
        end
        q0.push_back({1'b0, 32'h8000_0000});
        lg = PORT_INT;
        @(posedge clk); #1;
        e = q0.pop_front();
        checks++;
        if ({rr0.rsp_valid, rr0.rsp_zero, rr0.rsp_result} !== {1'b1, e}) begin
            errors++;
            $display("FAIL single_add got=%h exp=%h", {rr0.rsp_valid, rr0.rsp_zero, rr0.rsp_result}, {1'b1, e});
        end
        $display("single p0 add result=%h zero=%b", rr0.rsp_result, rr0.rsp_zero);
        drive_rr(1'b1, 32'd5, 32'd5, ALU_SUB, 1'b1, 1'b0, 32'd0, 32'd0, ALU_ADD, 1'b1);
        #2;
        checks++;
        if ({rr1.ready, rr0.ready} !== 2'b01) begin
            errors++;
            $display("FAIL single_grant_sub got=%b exp=01", {rr1.ready, rr0.ready});
        end
        q0.push_back({1'b1, 32'h0});
        @(posedge clk); #1;
        e = q0.pop_front();
        checks++;
        if ({rr0.rsp_valid, rr0.rsp_zero, rr0.rsp_result} !== {1'b1, e}) begin
            errors++;
            $display("FAIL single_sub got=%h exp=%h", {rr0.rsp_valid, rr0.rsp_zero, rr0.rsp_result}, {1'b1, e});
        end
        $display("single p0 sub result=%h zero=%b", rr0.rsp_result, rr0.rsp_zero);
        drive_rr(1'b0, 32'd0, 32'd0, ALU_ADD, 1'b1, 1'b0, 32'd0, 32'd0, ALU_ADD, 1'b1);
        @(posedge clk); #1;
        checks++;
        if ({rr0.rsp_valid, rr0.rsp_zero, rr0.rsp_result} !== {1'b0, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL single_drain got=%h exp=%h", {rr0.rsp_valid, rr0.rsp_zero, rr0.rsp_result}, {1'b0, 1'b1, 32'h0});
        end
    endtask

    task automatic test_backpressure();
        logic [32:0] e;
        drive_rr(1'b0, 32'd0, 32'd0, ALU_ADD, 1'b1, 1'b1, 32'h100, 32'h1, ALU_SUB, 1'b0);
        #2;
        checks++;
        if ({rr1.ready, rr0.ready} !== 2'b10) begin
            errors++;
            $display("FAIL bp_fill_grant got=%b exp=10", {rr1.ready, rr0.ready});
        end
        q1.push_back({1'b0, 32'hFF});
        lg = PORT_FP;
        @(posedge clk); #1;
        e = q1.pop_front();
        checks++;
        if ({rr1.rsp_valid, rr1.rsp_zero, rr1.rsp_result} !== {1'b1, e}) begin
            errors++;
            $display("FAIL bp_fill got=%h exp=%h", {rr1.rsp_valid, rr1.rsp_zero, rr1.rsp_result}, {1'b1, e});
        end
        for (int i = 0; i < 3; i++) begin
            drive_rr(1'b1, 32'(i + 1), 32'(i + 1), ALU_ADD, 1'b1, 1'b1, 32'h10, 32'h20, ALU_ADD, 1'b0);
            #2;
            checks++;
            if ({rr1.ready, rr0.ready} !== 2'b01) begin
                errors++;
                $display("FAIL bp_grant cyc=%0d got=%b exp=01", i, {rr1.ready, rr0.ready});
            end
            q0.push_back({1'b0, 32'(2 * (i + 1))});
            lg = PORT_INT;
            @(posedge clk); #1;
            e = q0.pop_front();
            checks++;
            if ({rr0.rsp_valid, rr0.rsp_zero, rr0.rsp_result} !== {1'b1, e}) begin
                errors++;
                $display("FAIL bp_rsp0 cyc=%0d got=%h exp=%h", i, {rr0.rsp_valid, rr0.rsp_zero, rr0.rsp_result}, {1'b1, e});
            end
            checks++;
            if ({rr1.rsp_valid, rr1.rsp_zero, rr1.rsp_result} !== {1'b1, 1'b0, 32'hFF}) begin
                errors++;
                $display("FAIL bp_hold1 cyc=%0d got=%h exp=%h", i, {rr1.rsp_valid, rr1.rsp_zero, rr1.rsp_result}, {1'b1, 1'b0, 32'hFF});
            end
            $display("backpressure cyc=%0d p0 result=%h p1 held=%h", i, rr0.rsp_result, rr1.rsp_result);
        end
        drive_rr(1'b1, 32'd9, 32'd1, ALU_ADD, 1'b1, 1'b1, 32'h10, 32'h20, ALU_ADD, 1'b1);
        #2;
        checks++;
        if ({rr1.ready, rr0.ready} !== 2'b10) begin
            errors++;
            $display("FAIL bp_release_grant got=%b exp=10", {rr1.ready, rr0.ready});
        end
        q1.push_back({1'b0, 32'h30});
        lg = PORT_FP;
        @(posedge clk); #1;
        e = q1.pop_front();
        checks++;
        if ({rr1.rsp_valid, rr1.rsp_zero, rr1.rsp_result} !== {1'b1, e}) begin
            errors++;
            $display("FAIL bp_release_rsp got=%h exp=%h", {rr1.rsp_valid, rr1.rsp_zero, rr1.rsp_result}, {1'b1, e});
        end
        checks++;
        if (rr0.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain0 got=%b exp=0", rr0.rsp_valid);
        end
        $display("backpressure release p1 result=%h", rr1.rsp_result);
        drive_rr(1'b0, 32'd0, 32'd0, ALU_ADD, 1'b1, 1'b0, 32'd0, 32'd0, ALU_ADD, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic test_fixed_priority();
        logic [32:0] e;
        drive_fp(1'b1, 32'hF0, 32'h0F, ALU_OR, 1'b1, 1'b1, 32'd4, 32'd4, ALU_SUB, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if ({fp1.ready, fp0.ready} !== 2'b01) begin
                errors++;
                $display("FAIL fp_grant cyc=%0d got=%b exp=01", i, {fp1.ready, fp0.ready});
            end
            fq0.push_back({1'b0, 32'hFF});
            @(posedge clk); #1;
            e = fq0.pop_front();
            checks++;
            if ({fp0.rsp_valid, fp0.rsp_zero, fp0.rsp_result} !== {1'b1, e}) begin
                errors++;
                $display("FAIL fp_rsp0 cyc=%0d got=%h exp=%h", i, {fp0.rsp_valid, fp0.rsp_zero, fp0.rsp_result}, {1'b1, e});
            end
            checks++;
            if (fp1.rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL fp_starve1 cyc=%0d got=%b exp=0", i, fp1.rsp_valid);
            end
            $display("fixed cyc=%0d p0 result=%h", i, fp0.rsp_result);
        end
        drive_fp(1'b0, 32'd0, 32'd0, ALU_ADD, 1'b1, 1'b1, 32'd4, 32'd4, ALU_SUB, 1'b1);
        #2;
        checks++;
        if ({fp1.ready, fp0.ready} !== 2'b10) begin
            errors++;
            $display("FAIL fp_p1_grant got=%b exp=10", {fp1.ready, fp0.ready});
        end
        fq1.push_back({1'b1, 32'h0});
        @(posedge clk); #1;
        e = fq1.pop_front();
        checks++;
        if ({fp1.rsp_valid, fp1.rsp_zero, fp1.rsp_result} !== {1'b1, e}) begin
            errors++;
            $display("FAIL fp_rsp1 got=%h exp=%h", {fp1.rsp_valid, fp1.rsp_zero, fp1.rsp_result}, {1'b1, e});
        end
        $display("fixed p1 result=%h zero=%b", fp1.rsp_result, fp1.rsp_zero);
        drive_fp(1'b0, 32'd0, 32'd0, ALU_ADD, 1'b1, 1'b0, 32'd0, 32'd0, ALU_ADD, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic test_wrap_idle();
        logic [1:0]  eg;
        logic [32:0] e;
        drive_rr(1'b0, 32'd0, 32'd0, ALU_ADD, 1'b1, 1'b1, 32'd0, 32'd1, ALU_SUB, 1'b1);
        #2;
        checks++;
        if ({rr1.ready, rr0.ready} !== 2'b10) begin
            errors++;
            $display("FAIL wrap_grant got=%b exp=10", {rr1.ready, rr0.ready});
        end
        q1.push_back({1'b0, 32'hFFFF_FFFF});
        lg = PORT_FP;
        @(posedge clk); #1;
        e = q1.pop_front();
        checks++;
        if ({rr1.rsp_valid, rr1.rsp_zero, rr1.rsp_result} !== {1'b1, e}) begin
            errors++;
            $display("FAIL wrap_rsp got=%h exp=%h", {rr1.rsp_valid, rr1.rsp_zero, rr1.rsp_result}, {1'b1, e});
        end
        $display("wrap p1 result=%h", rr1.rsp_result);
        // Operands toggle but nobody is valid: the ALU must see zeros.
        drive_rr(1'b0, 32'hDEAD_BEEF, 32'h1234_5678, ALU_OR, 1'b1, 1'b0, 32'hCAFE_F00D, 32'h5, ALU_SUB, 1'b1);
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++;
            if ({dut_rr.alu_a, dut_rr.alu_b, dut_rr.alu_ctrl, rr1.ready, rr0.ready} !== 68'd0) begin
                errors++;
                $display("FAIL idle_alu_in cyc=%0d a=%h b=%h ctrl=%b rdy=%b%b exp=0", i,
                         dut_rr.alu_a, dut_rr.alu_b, dut_rr.alu_ctrl, rr1.ready, rr0.ready);
            end
            @(posedge clk); #1;
        end
        drive_rr(1'b1, 32'd2, 32'd3, ALU_ADD, 1'b1, 1'b1, 32'hFF, 32'h0F, ALU_AND, 1'b1);
        eg = (lg == PORT_INT) ? 2'b10 : 2'b01;
        #2;
        checks++;
        if ({rr1.ready, rr0.ready} !== eg) begin
            errors++;
            $display("FAIL idle_lastgrant got=%b exp=%b", {rr1.ready, rr0.ready}, eg);
        end
        q0.push_back({1'b0, 32'h5});
        lg = PORT_INT;
        @(posedge clk); #1;
        e = q0.pop_front();
        checks++;
        if ({rr0.rsp_valid, rr0.rsp_zero, rr0.rsp_result} !== {1'b1, e}) begin
            errors++;
            $display("FAIL idle_after_rsp got=%h exp=%h", {rr0.rsp_valid, rr0.rsp_zero, rr0.rsp_result}, {1'b1, e});
        end
        $display("after idle p0 result=%h", rr0.rsp_result);
        drive_rr(1'b0, 32'd0, 32'd0, ALU_ADD, 1'b1, 1'b0, 32'd0, 32'd0, ALU_ADD, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [32:0] e;
        drive_rr(1'b1, 32'd1, 32'd2, ALU_ADD, 1'b0, 1'b0, 32'd0, 32'd0, ALU_ADD, 1'b1);
        #2;
        q0.push_back({1'b0, 32'h3});
        lg = PORT_INT;
        @(posedge clk); #1;
        e = q0.pop_front();
        checks++;
        if ({rr0.rsp_valid, rr0.rsp_zero, rr0.rsp_result} !== {1'b1, e}) begin
            errors++;
            $display("FAIL rstmid_fill got=%h exp=%h", {rr0.rsp_valid, rr0.rsp_zero, rr0.rsp_result}, {1'b1, e});
        end
        // p1 is granted mid-cycle, then reset hits before the edge.
        drive_rr(1'b0, 32'd0, 32'd0, ALU_ADD, 1'b0, 1'b1, 32'd9, 32'd4, ALU_SUB, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({rr0.rsp_valid, rr0.rsp_zero, rr0.rsp_result} !== 34'd0) begin
            errors++;
            $display("FAIL rstmid_async got=%h exp=0", {rr0.rsp_valid, rr0.rsp_zero, rr0.rsp_result});
        end
        checks++;
        if (rr1.ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ready got=%b exp=0", rr1.ready);
        end
        drive_rr(1'b0, 32'd0, 32'd0, ALU_ADD, 1'b1, 1'b0, 32'd0, 32'd0, ALU_ADD, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        lg  = PORT_FP;
        @(posedge clk); #1;
        checks++;
        if ({rr0.rsp_valid, rr1.rsp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_no_rsp got=%b exp=00", {rr0.rsp_valid, rr1.rsp_valid});
        end
        drive_rr(1'b1, 32'd6, 32'd1, ALU_SUB, 1'b1, 1'b1, 32'd1, 32'd1, ALU_ADD, 1'b1);
        #2;
        checks++;
        if ({rr1.ready, rr0.ready} !== 2'b01) begin
            errors++;
            $display("FAIL rstmid_first_grant got=%b exp=01", {rr1.ready, rr0.ready});
        end
        q0.push_back({1'b0, 32'h5});
        lg = PORT_INT;
        @(posedge clk); #1;
        e = q0.pop_front();
        checks++;
        if ({rr0.rsp_valid, rr0.rsp_zero, rr0.rsp_result} !== {1'b1, e}) begin
            errors++;
            $display("FAIL rstmid_first_rsp got=%h exp=%h", {rr0.rsp_valid, rr0.rsp_zero, rr0.rsp_result}, {1'b1, e});
        end
        $display("after mid reset p0 result=%h", rr0.rsp_result);
        drive_rr(1'b0, 32'd0, 32'd0, ALU_ADD, 1'b1, 1'b0, 32'd0, 32'd0, ALU_ADD, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        lg = PORT_FP;
        test_reset();
        test_contention_rr();
        test_single_port();
        test_backpressure();
        test_fixed_priority();
        test_wrap_idle();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
